// File: rtl/set_assoc_find_update.sv
// set_assoc_find_update: N-way set-associative lookup / fill engine with
// prefetcher check, hit/miss statistics and true-LRU replacement.
// Optional macro REPL_PLRU_EN swaps true LRU for tree pseudo-LRU.
`timescale 1ns/1ps
module set_assoc_find_update #(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    localparam int OFF_W  = $clog2(BLOCK_SIZE_BYTE),
    localparam int SET    = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    localparam int IDX_W  = $clog2(SET),
    localparam int TAG_W  = 32 - IDX_W - OFF_W,
    localparam int LRU_W  = (WAY > 1) ? $clog2(WAY) : 1,
    localparam int LINE_W = BLOCK_SIZE_BYTE * 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_cache,
    input  logic [TAG_W-1:0]  tag,
    input  logic [IDX_W-1:0]  index,
    input  logic [OFF_W-1:0]  block_offset,
    input  logic              update_cache_mem,
    input  logic [LINE_W-1:0] block_cache,
    input  logic              prefetch_hit,
    input  logic [LINE_W-1:0] prefetch_data,
    output logic              found_in_cache,
    output logic              found_in_prefetcher,
    output logic              done_cache,
    output logic              done_prefetch,
    output logic              updated_cache_mem,
    output logic              updated_cache_prefetch,
    output logic [LRU_W-1:0]  hit_way,
    output logic [15:0]       cache_hit_count,
    output logic [15:0]       cache_miss_count,
    output logic [4:0]        hit_latency
);

`ifdef REPL_PLRU_EN
    localparam int REPL_W = (WAY > 1) ? WAY - 1 : 1;

    // Tree nodes are heap-numbered from 1; node n lives in bit n-1.
    // A node bit of 1 means the victim lies in the right subtree.
    function automatic logic [REPL_W-1:0] repl_init();
        return '0;
    endfunction

    function automatic logic [REPL_W-1:0] repl_touch(input logic [REPL_W-1:0] st,
                                                    input logic [LRU_W-1:0]  w);
        logic [REPL_W-1:0] r;
        int n;
        r = st;
        n = 1;
        if (WAY > 1) begin
            for (int l = LRU_W - 1; l >= 0; l--) begin
                r[n-1] = ~w[l];
                n = 2 * n + int'(w[l]);
            end
        end
        return r;
    endfunction

    function automatic logic [LRU_W-1:0] repl_victim(input logic [REPL_W-1:0] st);
        logic [LRU_W-1:0] v;
        int n;
        v = '0;
        n = 1;
        if (WAY > 1) begin
            for (int l = LRU_W - 1; l >= 0; l--) begin
                v[l] = st[n-1];
                n = 2 * n + int'(st[n-1]);
            end
        end
        return v;
    endfunction
`else
    localparam int REPL_W = WAY * LRU_W;

    // Per-way age counters packed per set; age 0 is MRU, WAY-1 is LRU.
    function automatic logic [REPL_W-1:0] repl_init();
        logic [REPL_W-1:0] r;
        for (int i = 0; i < WAY; i++) r[i*LRU_W +: LRU_W] = LRU_W'(i);
        return r;
    endfunction

    function automatic logic [REPL_W-1:0] repl_touch(input logic [REPL_W-1:0] st,
                                                    input logic [LRU_W-1:0]  w);
        logic [REPL_W-1:0] r;
        logic [LRU_W-1:0]  tw;
        r  = st;
        tw = st[w*LRU_W +: LRU_W];
        for (int i = 0; i < WAY; i++) begin
            if (LRU_W'(i) == w)
                r[i*LRU_W +: LRU_W] = '0;
            else if (st[i*LRU_W +: LRU_W] < tw)
                r[i*LRU_W +: LRU_W] = st[i*LRU_W +: LRU_W] + 1'b1;
        end
        return r;
    endfunction

    function automatic logic [LRU_W-1:0] repl_victim(input logic [REPL_W-1:0] st);
        logic [LRU_W-1:0] v;
        v = '0;
        for (int i = 0; i < WAY; i++)
            if (st[i*LRU_W +: LRU_W] == LRU_W'(WAY - 1)) v = LRU_W'(i);
        return v;
    endfunction
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    typedef enum logic [1:0] {IDLE, LOOKUP, PF_WAIT, PF_CHECK} state_t;

    state_t state_q, state_d;

    logic [WAY-1:0]    valid_mem [SET];
    logic [REPL_W-1:0] repl_mem  [SET];
    logic [TAG_W-1:0]  tag_mem   [SET][WAY];
    logic [LINE_W-1:0] data_mem  [SET][WAY];

    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  lk_idx;
    logic              lk_hit;
    logic [LRU_W-1:0]  lk_way;
    logic [REPL_W-1:0] lk_repl;

    logic              mem_pend, pf_pend;
    logic [TAG_W-1:0]  mem_tag, pf_tag;
    logic [IDX_W-1:0]  mem_idx, pf_idx;
    logic [LINE_W-1:0] mem_data, pf_data;

    logic              fill_go;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [LINE_W-1:0] fill_data;
    logic [LRU_W-1:0]  victim;
    logic [REPL_W-1:0] fill_base;

    // Line data has no output port here; keep the offset and the read path referenced.
    logic unused_sink;
    assign unused_sink = ^{block_offset, data_mem[lk_idx][lk_way]};

    // Parallel tag compare across all ways of the latched set.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int i = 0; i < WAY; i++) begin
            if (valid_mem[lk_idx][i] && tag_mem[lk_idx][i] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = LRU_W'(i);
            end
        end
        lk_repl = repl_touch(repl_mem[lk_idx], lk_way);
    end

    // Fill arbitration (memory first) and victim choice: same tag, lowest invalid, then replacement policy.
    always_comb begin
        logic same_hit, inv_hit;
        logic [LRU_W-1:0] same_way, inv_way;
        fill_go   = mem_pend | pf_pend;
        fill_tag  = mem_pend ? mem_tag  : pf_tag;
        fill_idx  = mem_pend ? mem_idx  : pf_idx;
        fill_data = mem_pend ? mem_data : pf_data;
        same_hit  = 1'b0;
        same_way  = '0;
        inv_hit   = 1'b0;
        inv_way   = '0;
        for (int i = WAY - 1; i >= 0; i--) begin
            if (!valid_mem[fill_idx][i]) begin
                inv_hit = 1'b1;
                inv_way = LRU_W'(i);
            end
            if (valid_mem[fill_idx][i] && tag_mem[fill_idx][i] == fill_tag) begin
                same_hit = 1'b1;
                same_way = LRU_W'(i);
            end
        end
        victim = same_hit ? same_way : (inv_hit ? inv_way : repl_victim(repl_mem[fill_idx]));
        // A lookup touch on the same set lands first, the fill touch on top of it.
        fill_base = (state_q == LOOKUP && lk_hit && lk_idx == fill_idx) ? lk_repl : repl_mem[fill_idx];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_cache) state_d = LOOKUP;
            LOOKUP:   state_d = lk_hit ? IDLE : PF_WAIT;
            PF_WAIT:  state_d = PF_CHECK;
            PF_CHECK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs, statistics, request latch and fill pending flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_in_cache         <= 1'b0;
            found_in_prefetcher    <= 1'b0;
            done_cache             <= 1'b0;
            done_prefetch          <= 1'b0;
            updated_cache_mem      <= 1'b0;
            updated_cache_prefetch <= 1'b0;
            hit_way                <= '0;
            cache_hit_count        <= '0;
            cache_miss_count       <= '0;
            hit_latency            <= '0;
            lk_tag                 <= '0;
            lk_idx                 <= '0;
            mem_pend               <= 1'b0;
            pf_pend                <= 1'b0;
        end else begin
            done_cache             <= 1'b0;
            done_prefetch          <= 1'b0;
            updated_cache_mem      <= 1'b0;
            updated_cache_prefetch <= 1'b0;
            case (state_q)
                IDLE: begin
                    found_in_cache      <= 1'b0;
                    found_in_prefetcher <= 1'b0;
                    if (start_cache) begin
                        lk_tag      <= tag;
                        lk_idx      <= index;
                        hit_latency <= 5'd0;
                    end
                end
                LOOKUP: begin
                    done_cache     <= 1'b1;
                    found_in_cache <= lk_hit;
                    if (lk_hit) begin
                        hit_way         <= lk_way;
                        cache_hit_count <= sat_inc(cache_hit_count);
                        hit_latency     <= 5'd1;
                    end
                end
                PF_CHECK: begin
                    done_prefetch <= 1'b1;
                    if (prefetch_hit) begin
                        found_in_prefetcher <= 1'b1;
                        cache_hit_count     <= sat_inc(cache_hit_count);
                        hit_latency         <= 5'd3;
                    end else begin
                        cache_miss_count    <= sat_inc(cache_miss_count);
                    end
                end
                default: ;
            endcase
            if (fill_go) begin
                hit_way                <= victim;
                updated_cache_mem      <= mem_pend;
                updated_cache_prefetch <= ~mem_pend;
            end
            // A request arriving in its own write cycle is merged into that write.
            mem_pend <= mem_pend ? 1'b0 : update_cache_mem;
            pf_pend  <= pf_pend ? mem_pend : prefetch_hit;
        end
    end

    // Capture fill address and data when a new request is accepted.
    always_ff @(posedge clk) begin
        if (update_cache_mem && !mem_pend) begin
            mem_tag  <= tag;
            mem_idx  <= index;
            mem_data <= block_cache;
        end
        if (prefetch_hit && !pf_pend) begin
            pf_tag  <= tag;
            pf_idx  <= index;
            pf_data <= prefetch_data;
        end
    end

    // Valid bits and replacement state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SET; s++) begin
                valid_mem[s] <= '0;
                repl_mem[s]  <= repl_init();
            end
        end else begin
            if (state_q == LOOKUP && lk_hit) repl_mem[lk_idx] <= lk_repl;
            if (fill_go) begin
                valid_mem[fill_idx][victim] <= 1'b1;
                repl_mem[fill_idx]          <= repl_touch(fill_base, victim);
            end
        end
    end

    // Tag and data arrays (not reset; guarded by valid bits).
    always_ff @(posedge clk) begin
        if (fill_go) begin
            tag_mem[fill_idx][victim]  <= fill_tag;
            data_mem[fill_idx][victim] <= fill_data;
        end
    end

endmodule

// File: tb/tb_set_assoc_find_update.sv
// Self-checking bench for set_assoc_find_update (default build, WAY=4).
// Reference model: per-set recency list (MRU first) plus valid/tag arrays.
`timescale 1ns/1ps
module tb_set_assoc_find_update;
    localparam int WAY    = 4;
    localparam int BSB    = 16;
    localparam int CSB    = 32768;
    localparam int OFF_W  = 4;
    localparam int SET    = 512;
    localparam int IDX_W  = 9;
    localparam int TAG_W  = 19;
    localparam int LRU_W  = 2;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_cache;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  index;
    logic [OFF_W-1:0]  block_offset;
    logic              update_cache_mem;
    logic [LINE_W-1:0] block_cache;
    logic              prefetch_hit;
    logic [LINE_W-1:0] prefetch_data;
    logic              found_in_cache, found_in_prefetcher;
    logic              done_cache, done_prefetch;
    logic              updated_cache_mem, updated_cache_prefetch;
    logic [LRU_W-1:0]  hit_way;
    logic [15:0]       cache_hit_count, cache_miss_count;
    logic [4:0]        hit_latency;

    int checks = 0;
    int errors = 0;

    bit m_valid [SET][WAY];
    int m_tag   [SET][WAY];
    int m_ord   [SET][WAY];
    int m_hits, m_miss;

    set_assoc_find_update #(.WAY(WAY), .BLOCK_SIZE_BYTE(BSB), .CACHE_SIZE_BYTE(CSB)) dut (
        .clk(clk), .rst_n(rst_n), .start_cache(start_cache), .tag(tag), .index(index),
        .block_offset(block_offset), .update_cache_mem(update_cache_mem),
        .block_cache(block_cache), .prefetch_hit(prefetch_hit), .prefetch_data(prefetch_data),
        .found_in_cache(found_in_cache), .found_in_prefetcher(found_in_prefetcher),
        .done_cache(done_cache), .done_prefetch(done_prefetch),
        .updated_cache_mem(updated_cache_mem), .updated_cache_prefetch(updated_cache_prefetch),
        .hit_way(hit_way), .cache_hit_count(cache_hit_count),
        .cache_miss_count(cache_miss_count), .hit_latency(hit_latency));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int s = 0; s < SET; s++)
            for (int w = 0; w < WAY; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = 0;
                m_ord[s][w]   = w;
            end
        m_hits = 0;
        m_miss = 0;
    endfunction

    function automatic void m_touch(int s, int w);
        int pos = 0;
        for (int i = 0; i < WAY; i++) if (m_ord[s][i] == w) pos = i;
        for (int i = pos; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = w;
    endfunction

    function automatic int m_find(int s, int t);
        for (int i = 0; i < WAY; i++) if (m_valid[s][i] && m_tag[s][i] == t) return i;
        return -1;
    endfunction

    function automatic int m_fill(int s, int t);
        int w;
        w = m_find(s, t);
        if (w < 0) begin
            w = m_ord[s][WAY-1];
            for (int i = WAY - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
        end
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = t;
        m_touch(s, w);
        return w;
    endfunction

    function automatic void m_count(bit hit);
        if (hit) begin if (m_hits < 65535) m_hits++; end
        else     begin if (m_miss < 65535) m_miss++; end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic do_lookup(input int t, input int s, input bit pf);
        int w;
        bit hit;
        w   = m_find(s, t);
        hit = (w >= 0);
        tag = TAG_W'(t); index = IDX_W'(s); start_cache = 1'b1;
        tick();
        start_cache = 1'b0;
        checks++; if (done_cache !== 1'b0) begin errors++; $display("FAIL lk_done_early t=%0d got %0b exp 0", t, done_cache); end
        tick();
        checks++; if (done_cache !== 1'b1) begin errors++; $display("FAIL lk_done t=%0d got %0b exp 1", t, done_cache); end
        checks++; if (found_in_cache !== hit) begin errors++; $display("FAIL lk_found t=%0d s=%0d got %0b exp %0b", t, s, found_in_cache, hit); end
        if (hit) begin
            m_touch(s, w);
            m_count(1'b1);
            checks++; if (hit_way !== LRU_W'(w)) begin errors++; $display("FAIL lk_hit_way t=%0d got %0d exp %0d", t, hit_way, w); end
            checks++; if (hit_latency !== 5'd1) begin errors++; $display("FAIL lk_latency got %0d exp 1", hit_latency); end
            checks++; if (cache_hit_count !== 16'(m_hits)) begin errors++; $display("FAIL lk_hit_count got %0d exp %0d", cache_hit_count, m_hits); end
        end else begin
            tick();
            checks++; if (done_cache !== 1'b0) begin errors++; $display("FAIL lk_done_width got %0b exp 0", done_cache); end
            prefetch_hit = pf; prefetch_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            prefetch_hit = 1'b0;
            m_count(pf);
            checks++; if (done_prefetch !== 1'b1) begin errors++; $display("FAIL pf_done got %0b exp 1", done_prefetch); end
            checks++; if (found_in_prefetcher !== pf) begin errors++; $display("FAIL pf_found got %0b exp %0b", found_in_prefetcher, pf); end
            checks++; if (hit_latency !== (pf ? 5'd3 : 5'd0)) begin errors++; $display("FAIL pf_latency got %0d exp %0d", hit_latency, pf ? 3 : 0); end
            checks++; if (cache_hit_count !== 16'(m_hits)) begin errors++; $display("FAIL pf_hit_count got %0d exp %0d", cache_hit_count, m_hits); end
            checks++; if (cache_miss_count !== 16'(m_miss)) begin errors++; $display("FAIL pf_miss_count got %0d exp %0d", cache_miss_count, m_miss); end
            if (pf) begin
                tick();
                w = m_fill(s, t);
                checks++; if (updated_cache_prefetch !== 1'b1) begin errors++; $display("FAIL pf_updated got %0b exp 1", updated_cache_prefetch); end
                checks++; if (hit_way !== LRU_W'(w)) begin errors++; $display("FAIL pf_fill_way t=%0d got %0d exp %0d", t, hit_way, w); end
            end
        end
        tick();
        checks++; if ({found_in_cache, done_cache, done_prefetch} !== 3'b000) begin errors++; $display("FAIL lk_pulse_clear got %b exp 000", {found_in_cache, done_cache, done_prefetch}); end
    endtask

    task automatic do_mem_fill(input int t, input int s);
        int w;
        tag = TAG_W'(t); index = IDX_W'(s);
        block_cache = {$urandom, $urandom, $urandom, $urandom};
        update_cache_mem = 1'b1;
        tick();
        update_cache_mem = 1'b0;
        checks++; if (updated_cache_mem !== 1'b0) begin errors++; $display("FAIL fill_early got %0b exp 0", updated_cache_mem); end
        tick();
        w = m_fill(s, t);
        checks++; if (updated_cache_mem !== 1'b1) begin errors++; $display("FAIL fill_updated t=%0d got %0b exp 1", t, updated_cache_mem); end
        checks++; if (hit_way !== LRU_W'(w)) begin errors++; $display("FAIL fill_way t=%0d s=%0d got %0d exp %0d", t, s, hit_way, w); end
        tick();
        checks++; if (updated_cache_mem !== 1'b0) begin errors++; $display("FAIL fill_width got %0b exp 0", updated_cache_mem); end
    endtask

    task automatic do_dual_fill(input int t, input int s);
        int w;
        tag = TAG_W'(t); index = IDX_W'(s);
        block_cache = {$urandom, $urandom, $urandom, $urandom};
        prefetch_data = {$urandom, $urandom, $urandom, $urandom};
        update_cache_mem = 1'b1; prefetch_hit = 1'b1;
        tick();
        update_cache_mem = 1'b0; prefetch_hit = 1'b0;
        checks++; if ({updated_cache_mem, updated_cache_prefetch} !== 2'b00) begin errors++; $display("FAIL dual_early got %b exp 00", {updated_cache_mem, updated_cache_prefetch}); end
        tick();
        w = m_fill(s, t);
        checks++; if ({updated_cache_mem, updated_cache_prefetch} !== 2'b10) begin errors++; $display("FAIL dual_first got %b exp 10", {updated_cache_mem, updated_cache_prefetch}); end
        checks++; if (hit_way !== LRU_W'(w)) begin errors++; $display("FAIL dual_first_way got %0d exp %0d", hit_way, w); end
        tick();
        w = m_fill(s, t);
        checks++; if ({updated_cache_mem, updated_cache_prefetch} !== 2'b01) begin errors++; $display("FAIL dual_second got %b exp 01", {updated_cache_mem, updated_cache_prefetch}); end
        checks++; if (hit_way !== LRU_W'(w)) begin errors++; $display("FAIL dual_second_way got %0d exp %0d", hit_way, w); end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_cache = 1'b0; tag = '0; index = '0; block_offset = '0;
        update_cache_mem = 1'b0; block_cache = '0; prefetch_hit = 1'b0; prefetch_data = '0;
        m_reset();
        tick(); tick();
        checks++; if ({found_in_cache, found_in_prefetcher, done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 0", {found_in_cache, found_in_prefetcher, done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch}); end
        checks++; if ({hit_way, cache_hit_count, cache_miss_count, hit_latency} !== '0) begin errors++; $display("FAIL reset_values way=%0d hits=%0d miss=%0d lat=%0d exp all 0", hit_way, cache_hit_count, cache_miss_count, hit_latency); end
        rst_n = 1'b1;
        tick();
        checks++; if ({done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch} !== 4'b0) begin errors++; $display("FAIL reset_release got %b exp 0", {done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch}); end
    endtask

    task automatic test_miss_fill_hit();
        do_lookup(1, 3, 1'b0);
        do_mem_fill(1, 3);
        do_lookup(1, 3, 1'b0);
    endtask

    task automatic test_lru_evict();
        for (int t = 1; t <= 5; t++) do_mem_fill(t, 7);
        do_lookup(1, 7, 1'b0);
        do_lookup(5, 7, 1'b0);
        for (int t = 1; t <= 4; t++) do_mem_fill(t, 8);
        do_lookup(1, 8, 1'b0);
        do_mem_fill(5, 8);
        do_lookup(2, 8, 1'b0);
    endtask

    task automatic test_prefetch();
        do_lookup(33, 10, 1'b1);
        do_lookup(33, 10, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_mem_fill(1, 12);
        do_dual_fill(2, 12);
        do_lookup(2, 12, 1'b0);
    endtask

    task automatic test_lookup_fill_overlap();
        int w;
        tag = TAG_W'(9); index = IDX_W'(20);
        block_cache = {$urandom, $urandom, $urandom, $urandom};
        start_cache = 1'b1; update_cache_mem = 1'b1;
        tick();
        start_cache = 1'b0; update_cache_mem = 1'b0;
        tick();
        w = m_fill(20, 9);
        checks++; if (done_cache !== 1'b1) begin errors++; $display("FAIL ovl_done got %0b exp 1", done_cache); end
        checks++; if (found_in_cache !== 1'b0) begin errors++; $display("FAIL ovl_prewrite got %0b exp 0", found_in_cache); end
        checks++; if (updated_cache_mem !== 1'b1) begin errors++; $display("FAIL ovl_updated got %0b exp 1", updated_cache_mem); end
        checks++; if (hit_way !== LRU_W'(w)) begin errors++; $display("FAIL ovl_way got %0d exp %0d", hit_way, w); end
        tick();
        tick();
        m_count(1'b0);
        checks++; if (done_prefetch !== 1'b1) begin errors++; $display("FAIL ovl_pf_done got %0b exp 1", done_prefetch); end
        checks++; if (cache_miss_count !== 16'(m_miss)) begin errors++; $display("FAIL ovl_miss got %0d exp %0d", cache_miss_count, m_miss); end
        tick();
        do_lookup(9, 20, 1'b0);
    endtask

    task automatic test_random();
        int t, s, op;
        for (int n = 0; n < 40; n++) begin
            s  = 40 + int'($urandom_range(0, 2));
            t  = int'($urandom_range(1, 7));
            op = int'($urandom_range(0, 3));
            case (op)
                0, 1: do_lookup(t, s, bit'($urandom_range(0, 1)));
                2:    do_mem_fill(t, s);
                default: do_dual_fill(t, s);
            endcase
        end
    endtask

    task automatic test_reset_mid();
        tag = TAG_W'(77); index = IDX_W'(30);
        block_cache = {$urandom, $urandom, $urandom, $urandom};
        start_cache = 1'b1; update_cache_mem = 1'b1;
        tick();
        start_cache = 1'b0; update_cache_mem = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({found_in_cache, found_in_prefetcher, done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch} !== 6'b0) begin errors++; $display("FAIL rmid_flags got %b exp 0", {found_in_cache, found_in_prefetcher, done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch}); end
        checks++; if ({hit_way, cache_hit_count, cache_miss_count, hit_latency} !== '0) begin errors++; $display("FAIL rmid_values hits=%0d miss=%0d lat=%0d exp 0", cache_hit_count, cache_miss_count, hit_latency); end
        m_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch} !== 4'b0) begin errors++; $display("FAIL rmid_pulse cyc=%0d got %b exp 0", i, {done_cache, done_prefetch, updated_cache_mem, updated_cache_prefetch}); end
        end
        do_lookup(77, 30, 1'b0);
    endtask

    initial begin
        test_reset();
        test_miss_fill_hit();
        test_lru_evict();
        test_prefetch();
        test_back_to_back();
        test_lookup_fill_overlap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/set_assoc_find_update.md
Name: set_assoc_find_update

Overview:
Parametrised N-way set-associative successor to the direct-mapped lookup/update engine in the cache simulator.
- Looks up tag/index across all ways in parallel.
- On a cache miss, checks the prefetcher. Accumulates hit/miss statistics.
- Fills lines from main memory or from the prefetcher, using true-LRU replacement.
- Sits between the request generator and the memory/prefetcher models.

Parameters:
- WAY, 4, associativity; power of two, 1..8 (1 = direct-mapped).
- BLOCK_SIZE_BYTE, 16, line size in bytes.
- CACHE_SIZE_BYTE, 32768, total data capacity in bytes.
- Derived, not overridable: OFF_W = log2(BLOCK_SIZE_BYTE); SET = CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAY); IDX_W = log2(SET); TAG_W = 32-IDX_W-OFF_W; LRU_W = max(1, log2(WAY)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_cache  in  1  start lookup; sampled in IDLE only.
- tag  in  TAG_W  request tag; held stable until done_*/updated_* pulses.
- index  in  IDX_W  set index.
- block_offset  in  OFF_W  byte offset; unused internally.
- update_cache_mem  in  1  memory fill request, 1-cycle pulse.
- block_cache  in  BLOCK_SIZE_BYTE*8  memory fill data.
- prefetch_hit  in  1  prefetcher holds the block; also acts as the prefetch fill request.
- prefetch_data  in  BLOCK_SIZE_BYTE*8  prefetcher fill data.
- found_in_cache  out  1  lookup hit in cache.
- found_in_prefetcher  out  1  hit in prefetcher after a cache miss.
- done_cache  out  1  cache lookup complete, 1-cycle pulse.
- done_prefetch  out  1  prefetch check complete, 1-cycle pulse.
- updated_cache_mem  out  1  memory fill written, 1-cycle pulse.
- updated_cache_prefetch  out  1  prefetch fill written, 1-cycle pulse.
- hit_way  out  LRU_W  way that hit, or way that was filled.
- cache_hit_count  out  16  total hits.
- cache_miss_count  out  16  total misses.
- hit_latency  out  5  latency of the last request.

Behaviour:
- Reset (async):
  - All outputs 0; FSM to IDLE; fill pending flags 0.
  - All valid bits 0; LRU ages initialised to way number.
  - Tag/data arrays are not reset.
- Lookup FSM:
  - IDLE: clears found_*/done_*. On start_cache=1: latch request, hit_latency<=0, go to LOOKUP.
  - LOOKUP (1 cycle): compare tag against all valid ways of set index.
    - Hit: found_in_cache=1, done_cache=1, hit_way=matching way, hit_count+1, hit_latency=1, promote way to MRU, next state IDLE.
    - Miss: done_cache=1, found_in_cache=0, next state PF_WAIT.
  - PF_WAIT: one dead cycle, then PF_CHECK.
  - PF_CHECK: sample prefetch_hit.
    - 1: found_in_prefetcher=1, hit_count+1, hit_latency=3.
    - 0: miss_count+1, hit_latency unchanged at 0.
    - done_prefetch=1 either way; next state IDLE.
- Fill:
  - Request on update_cache_mem or prefetch_hit sets a pending flag.
  - Next edge writes {valid=1, tag, data} into the victim way and pulses updated_*; victim way is reported on hit_way.
  - Victim selection, in priority order:
    1. Way already holding the same tag (no duplicates).
    2. Lowest-numbered invalid way.
    3. LRU way (age = WAY-1).
  - Filled way becomes MRU.
- LRU: per-set age counters, LRU_W bits per way. On touch, ways younger than the touched way age by 1; the touched way goes to 0. Ages stay a permutation of 0..WAY-1.
- Simultaneous events:
  - Memory and prefetch fill pending together: memory fill writes first; prefetch fill writes the following cycle.
  - A fill pulse is never dropped. A fill request during its own pending cycle is merged.
- LOOKUP and fill in the same cycle to the same set: the lookup sees pre-write contents; the LRU update from the fill is applied after the lookup's LRU update.
- Counters saturate at 16'hFFFF.
- Reset mid-operation aborts the lookup and any pending fills; no done/updated pulse is produced.

Optional Feature:
- REPL_PLRU_EN
  - Defined: tree pseudo-LRU replaces true LRU, WAY-1 bits per set. Bits on the path are flipped away from the touched way; the victim is found by following the bits.
  - Undefined: true-LRU age counters as described above.
  - Invalid-way and same-tag priority is unchanged in both modes.

Test Plan:
- Reset, then lookup tag 0x1, index 3 -> done_cache pulses 2 cycles after start; PF_CHECK with prefetch_hit=0 -> miss_count=1, done_prefetch pulses.
- Memory fill tag 0x1, index 3 -> updated_cache_mem pulses, hit_way=0. Re-lookup -> found_in_cache=1, hit_way=0, hit_latency=1, hit_count=1.
- Fill tags 0x1..0x5 into set 7 with WAY=4 -> 5th fill evicts tag 0x1 (way 0). Lookup 0x1 -> miss; lookup 0x5 -> hit_way=0.
- Touch way 0 between fills 4 and 5 -> victim becomes way 1.
- Miss, then prefetch_hit=1 at PF_CHECK -> found_in_prefetcher=1, hit_latency=3, updated_cache_prefetch pulses, hit_count+1.
- update_cache_mem and prefetch_hit in the same cycle -> updated_cache_mem, then updated_cache_prefetch one cycle later. Drop rst_n mid-LOOKUP -> all outputs 0, no pulses.
